// File: rtl/ycc_stream_sched_pkg.sv
// Shared encodings for the YCbCr stream scheduler: channel codes,
// scheduler states and the default bitstream word width.
package ycc_stream_sched_pkg;

  localparam int DATA_W_DEFAULT = 32;

  localparam logic [1:0] CH_Y  = 2'd0;
  localparam logic [1:0] CH_CB = 2'd1;
  localparam logic [1:0] CH_CR = 2'd2;

  // State encoding equals the channel code so cur_chan is the state itself
  typedef enum logic [1:0] {
    SERVE_Y  = CH_Y,
    SERVE_CB = CH_CB,
    SERVE_CR = CH_CR
  } state_e;

  // Channel rotation Y -> Cb -> Cr -> Y
  function automatic state_e nextChannel(input state_e cur);
    case (cur)
      SERVE_Y:  nextChannel = SERVE_CB;
      SERVE_CB: nextChannel = SERVE_CR;
      default:  nextChannel = SERVE_Y;
    endcase
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Synchronous show-ahead FIFO: dout always shows the oldest word, rd_en
// consumes it. Writes while full are ignored; the caller flags the drop.
module sched_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             doWrite, doRead;

  // Accept a write only with room before the edge; read only when data exists
  always_comb begin
    doWrite = wr_en && (count_q != FULL_COUNT);
    doRead  = rd_en && (count_q != '0);
    wrPtr_d = doWrite ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d = doRead  ? rdPtr_q + AW'(1) : rdPtr_q;
    case ({doWrite, doRead})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy guards them
  always_ff @(posedge clk) begin
    if (rst && doWrite) begin
      mem_q[wrPtr_q] <= din;
    end
  end

  assign dout  = mem_q[rdPtr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/ycc_stream_sched.sv
// Merges Y, Cb and Cr Huffman word streams into one JPEG bitstream,
// emitting whole 8x8 blocks in Y, Cb, Cr order from per-channel FIFOs.
module ycc_stream_sched
  import ycc_stream_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] y_bitstream,
  input  logic              y_data_ready,
  input  logic              y_eob,
  input  logic [DATA_W-1:0] cb_bitstream,
  input  logic              cb_data_ready,
  input  logic              cb_eob,
  input  logic [DATA_W-1:0] cr_bitstream,
  input  logic              cr_data_ready,
  input  logic              cr_eob,
  output logic [DATA_W-1:0] JPEG_bitstream,
  output logic              data_ready,
  output logic              eob_out,
  output logic              mcu_done,
  output logic [1:0]        cur_chan,
  output logic [2:0]        overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [2:0]      fifoWr;
  logic [2:0]      fifoRd;
  logic [2:0]      fifoEmpty;
  logic [DATA_W:0] fifoDin   [3];
  logic [DATA_W:0] fifoDout  [3];
  logic [CW-1:0]   fifoCount [3];

  state_e          state_q, state_d;
  logic            pop;
  logic [DATA_W:0] popWord;

  logic [DATA_W-1:0] jpeg_q;
  logic              dataReady_q;
  logic              eob_q;
  logic              mcuDone_q;
  logic [2:0]        overflow_q, overflow_d;

  assign fifoWr     = {cr_data_ready, cb_data_ready, y_data_ready};
  assign fifoDin[0] = {y_eob,  y_bitstream};
  assign fifoDin[1] = {cb_eob, cb_bitstream};
  assign fifoDin[2] = {cr_eob, cr_bitstream};

  for (genvar i = 0; i < 3; i++) begin : gChanFifo
    sched_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W + 1)
    ) uFifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (fifoWr[i]),
      .rd_en (fifoRd[i]),
      .din   (fifoDin[i]),
      .dout  (fifoDout[i]),
      .empty (fifoEmpty[i]),
      .count (fifoCount[i])
    );
  end

  // Scheduler state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SERVE_Y;
    end else begin
      state_q <= state_d;
    end
  end

  // Advance to the next channel when the word leaving now closes a block
  always_comb begin
    state_d = state_q;
    if (pop && popWord[DATA_W]) begin
      state_d = nextChannel(state_q);
    end
  end

  // Pop the served FIFO whenever it holds data; other FIFOs only fill
  always_comb begin
    fifoRd  = 3'b000;
    pop     = 1'b0;
    popWord = '0;
    case (state_q)
      SERVE_Y: begin
        pop     = !fifoEmpty[0];
        popWord = fifoDout[0];
        fifoRd  = {2'b00, !fifoEmpty[0]};
      end
      SERVE_CB: begin
        pop     = !fifoEmpty[1];
        popWord = fifoDout[1];
        fifoRd  = {1'b0, !fifoEmpty[1], 1'b0};
      end
      SERVE_CR: begin
        pop     = !fifoEmpty[2];
        popWord = fifoDout[2];
        fifoRd  = {!fifoEmpty[2], 2'b00};
      end
      default: begin
        pop     = 1'b0;
        popWord = '0;
        fifoRd  = 3'b000;
      end
    endcase
  end

  // Sticky drop flags: a word offered to a full FIFO is lost even if it pops
  always_comb begin
    overflow_d = overflow_q;
    for (int i = 0; i < 3; i++) begin
      if (fifoWr[i] && (fifoCount[i] == FULL_COUNT)) begin
        overflow_d[i] = 1'b1;
      end
    end
  end

  // Output registers; the word bus holds its last value between pops
  always_ff @(posedge clk) begin
    if (!rst) begin
      jpeg_q      <= '0;
      dataReady_q <= 1'b0;
      eob_q       <= 1'b0;
      mcuDone_q   <= 1'b0;
      overflow_q  <= 3'b000;
    end else begin
      overflow_q <= overflow_d;
      if (pop) begin
        jpeg_q      <= popWord[DATA_W-1:0];
        dataReady_q <= 1'b1;
        eob_q       <= popWord[DATA_W];
        mcuDone_q   <= popWord[DATA_W] && (state_q == SERVE_CR);
      end else begin
        dataReady_q <= 1'b0;
        eob_q       <= 1'b0;
        mcuDone_q   <= 1'b0;
      end
    end
  end

  assign JPEG_bitstream = jpeg_q;
  assign data_ready     = dataReady_q;
  assign eob_out        = eob_q;
  assign mcu_done       = mcuDone_q;
  assign cur_chan       = state_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_ycc_stream_sched.sv
// Directed testbench for ycc_stream_sched with a scoreboard queue of
// expected output words and an independent output monitor.
module tb_ycc_stream_sched;
  import ycc_stream_sched_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] y_bitstream, cb_bitstream, cr_bitstream;
  logic          y_data_ready, cb_data_ready, cr_data_ready;
  logic          y_eob, cb_eob, cr_eob;
  logic [DW-1:0] JPEG_bitstream;
  logic          data_ready, eob_out, mcu_done;
  logic [1:0]    cur_chan;
  logic [2:0]    overflow;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          eob;
    logic          mcu;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  ycc_stream_sched #(
    .FIFO_DEPTH (DEPTH),
    .DATA_W     (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .y_bitstream    (y_bitstream),
    .y_data_ready   (y_data_ready),
    .y_eob          (y_eob),
    .cb_bitstream   (cb_bitstream),
    .cb_data_ready  (cb_data_ready),
    .cb_eob         (cb_eob),
    .cr_bitstream   (cr_bitstream),
    .cr_data_ready  (cr_data_ready),
    .cr_eob         (cr_eob),
    .JPEG_bitstream (JPEG_bitstream),
    .data_ready     (data_ready),
    .eob_out        (eob_out),
    .mcu_done       (mcu_done),
    .cur_chan       (cur_chan),
    .overflow       (overflow)
  );

  // Single comparison point used by both the monitor and direct checks
  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expectWord(input logic [DW-1:0] data, input logic eob, input logic mcu);
    exp_t e;
    e.data = data;
    e.eob  = eob;
    e.mcu  = mcu;
    expQ.push_back(e);
  endtask

  task automatic clearInputs();
    y_bitstream   = '0; y_data_ready  = 1'b0; y_eob  = 1'b0;
    cb_bitstream  = '0; cb_data_ready = 1'b0; cb_eob = 1'b0;
    cr_bitstream  = '0; cr_data_ready = 1'b0; cr_eob = 1'b0;
  endtask

  // Present one word on one channel for exactly one rising edge
  task automatic applyStimulus(input logic [1:0] ch, input logic [DW-1:0] w, input logic e);
    @(negedge clk);
    clearInputs();
    case (ch)
      CH_Y:    begin y_bitstream  = w; y_data_ready  = 1'b1; y_eob  = e; end
      CH_CB:   begin cb_bitstream = w; cb_data_ready = 1'b1; cb_eob = e; end
      default: begin cr_bitstream = w; cr_data_ready = 1'b1; cr_eob = e; end
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clearInputs();
    end
  endtask

  // Bounded wait for the scoreboard to empty
  task automatic waitDrain(input string name);
    for (int i = 0; i < 300 && expQ.size() != 0; i++) begin
      @(negedge clk);
      clearInputs();
    end
    checkOutput({name, "_drain_left"}, 32'(expQ.size()), 32'd0);
    idle(2);
  endtask

  // Monitor: every emitted word must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (data_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_word: got %0h, expected no output", JPEG_bitstream);
      end else begin
        e = expQ.pop_front();
        checkOutput("word", JPEG_bitstream, e.data);
        checkOutput("eob_out", 32'(eob_out), 32'(e.eob));
        checkOutput("mcu_done", 32'(mcu_done), 32'(e.mcu));
      end
    end else if (data_ready === 1'b0 && rst === 1'b1) begin
      if (eob_out !== 1'b0 || mcu_done !== 1'b0) begin
        checkOutput("idle_flags", 32'({eob_out, mcu_done}), 32'd0);
      end
    end
  end

  initial begin
    clearInputs();

    // Reset state
    rst = 1'b0;
    idle(2);
    checkOutput("rst_data_ready", 32'(data_ready), 32'd0);
    checkOutput("rst_eob_out", 32'(eob_out), 32'd0);
    checkOutput("rst_mcu_done", 32'(mcu_done), 32'd0);
    checkOutput("rst_jpeg", JPEG_bitstream, 32'd0);
    checkOutput("rst_cur_chan", 32'(cur_chan), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b1;
    idle(2);

    // Basic MCU: Y of 3, Cb of 1, Cr of 2
    expectWord(32'hA0, 1'b0, 1'b0);
    expectWord(32'hA1, 1'b0, 1'b0);
    expectWord(32'hA2, 1'b1, 1'b0);
    expectWord(32'hB0, 1'b1, 1'b0);
    expectWord(32'hC0, 1'b0, 1'b0);
    expectWord(32'hC1, 1'b1, 1'b1);
    applyStimulus(CH_Y,  32'hA0, 1'b0);
    applyStimulus(CH_Y,  32'hA1, 1'b0);
    applyStimulus(CH_Y,  32'hA2, 1'b1);
    applyStimulus(CH_CB, 32'hB0, 1'b1);
    applyStimulus(CH_CR, 32'hC0, 1'b0);
    applyStimulus(CH_CR, 32'hC1, 1'b1);
    waitDrain("mcu_basic");
    checkOutput("mcu_basic_chan", 32'(cur_chan), 32'd0);

    // Minimum latency of two edges and immediate channel advance
    expectWord(32'h37, 1'b1, 1'b0);
    applyStimulus(CH_Y, 32'h37, 1'b1);
    @(negedge clk); clearInputs();
    checkOutput("lat_edge_e", 32'(data_ready), 32'd0);
    @(negedge clk); clearInputs();
    checkOutput("lat_edge_e1", 32'(data_ready), 32'd1);
    checkOutput("lat_chan_e1", 32'(cur_chan), 32'd1);
    expectWord(32'h3B, 1'b1, 1'b0);
    expectWord(32'h3C, 1'b1, 1'b1);
    applyStimulus(CH_CB, 32'h3B, 1'b1);
    applyStimulus(CH_CR, 32'h3C, 1'b1);
    waitDrain("latency");

    // Cr arrives first and must wait for Y and Cb
    expectWord(32'h400, 1'b1, 1'b0);
    expectWord(32'h410, 1'b1, 1'b0);
    expectWord(32'h420, 1'b0, 1'b0);
    expectWord(32'h421, 1'b1, 1'b1);
    applyStimulus(CH_CR, 32'h420, 1'b0);
    applyStimulus(CH_CR, 32'h421, 1'b1);
    idle(4);
    checkOutput("cr_early_hold", 32'(data_ready), 32'd0);
    checkOutput("cr_early_chan", 32'(cur_chan), 32'd0);
    applyStimulus(CH_Y,  32'h400, 1'b1);
    applyStimulus(CH_CB, 32'h410, 1'b1);
    waitDrain("cr_early");

    // Cb overflow while Y is served: 17th word dropped
    expectWord(32'h5F0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) expectWord(32'h500 + 32'(i), i == 15, 1'b0);
    expectWord(32'h5C0, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) applyStimulus(CH_CB, 32'h500 + 32'(i), i == 15);
    @(negedge clk); clearInputs();
    checkOutput("cb_overflow", 32'(overflow), 32'h2);
    applyStimulus(CH_Y,  32'h5F0, 1'b1);
    applyStimulus(CH_CR, 32'h5C0, 1'b1);
    waitDrain("overflow");
    checkOutput("overflow_sticky", 32'(overflow), 32'h2);

    // Reset mid-block with 5 Y words buffered while serving Cb
    expectWord(32'h600, 1'b1, 1'b0);
    applyStimulus(CH_Y, 32'h600, 1'b1);
    for (int i = 1; i <= 5; i++) applyStimulus(CH_Y, 32'h600 + 32'(i), 1'b0);
    waitDrain("pre_reset");
    checkOutput("pre_reset_chan", 32'(cur_chan), 32'd1);
    @(negedge clk);
    clearInputs();
    rst = 1'b0;
    y_bitstream = 32'hDEAD; y_data_ready = 1'b1;
    expQ.delete();
    @(negedge clk);
    clearInputs();
    rst = 1'b1;
    checkOutput("mid_rst_data_ready", 32'(data_ready), 32'd0);
    checkOutput("mid_rst_jpeg", JPEG_bitstream, 32'd0);
    checkOutput("mid_rst_chan", 32'(cur_chan), 32'd0);
    checkOutput("mid_rst_overflow", 32'(overflow), 32'd0);
    expectWord(32'h6A0, 1'b1, 1'b0);
    expectWord(32'h6B0, 1'b1, 1'b0);
    expectWord(32'h6C0, 1'b1, 1'b1);
    applyStimulus(CH_Y,  32'h6A0, 1'b1);
    applyStimulus(CH_CB, 32'h6B0, 1'b1);
    applyStimulus(CH_CR, 32'h6C0, 1'b1);
    waitDrain("post_reset");

    // Continuous Y input: full rate until eob, then Y stalls behind Cb/Cr
    for (int i = 0; i < 3; i++) expectWord(32'h700 + 32'(i), i == 2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clearInputs();
      y_bitstream  = 32'h700 + 32'(i);
      y_data_ready = 1'b1;
      y_eob        = (i == 2) || (i == 5);
      if (i >= 2) checkOutput($sformatf("stream_rate_%0d", i), 32'(data_ready), 32'(i <= 4));
    end
    idle(8);
    checkOutput("stream_stall_chan", 32'(cur_chan), 32'd1);
    checkOutput("stream_stall_left", 32'(expQ.size()), 32'd0);
    expectWord(32'h7B0, 1'b1, 1'b0);
    expectWord(32'h7C0, 1'b1, 1'b1);
    for (int i = 3; i < 6; i++) expectWord(32'h700 + 32'(i), i == 5, 1'b0);
    applyStimulus(CH_CB, 32'h7B0, 1'b1);
    applyStimulus(CH_CR, 32'h7C0, 1'b1);
    waitDrain("stream");
    checkOutput("stream_end_chan", 32'(cur_chan), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
